neopixel_strand_driver: RTL and testbench
=========================================

Name: neopixel_strand_driver

Overview:
- Parametrised successor to the single-strand NeoPixel controller.
- Holds a persistent colour buffer of NUM_PIXELS GRB words, loaded one channel at a time.
- On request, serialises the buffer onto neo_data as a WS2812 waveform with configurable high/low cycle counts, then holds the latch gap.
- Sits between the host command logic and the strand data pin.

Parameters:
- NUM_PIXELS, 5: pixels on the strand, 1..256.
- T0H_CYC, 18: clock cycles neo_data is high for a 0 bit.
- T1H_CYC, 35: clock cycles neo_data is high for a 1 bit.
- BIT_CYC, 63: total clock cycles per bit. Requires T1H_CYC < BIT_CYC and T0H_CYC < T1H_CYC.
- LATCH_CYC, 2500: low cycles after a packet (50 us at 50 MHz).

Ports:
- clock  in  1  system clock, 50 MHz nominal.
- reset  in  1  asynchronous, active-high.
- color_level  in  8  channel intensity to load.
- color_index  in  2  00=R, 01=B, 10=G, 11=reserved (W with option).
- pixel_index  in  PIX_W  target pixel; PIX_W = max(1, $clog2(NUM_PIXELS)).
- load_color  in  1  write color_level into the buffer this cycle.
- send_it  in  1  request one packet transmission.
- neo_data  out  1  serial strand data.
- ready_to_load  out  1  load_color is accepted this cycle.
- ready_to_send  out  1  send_it is accepted this cycle.

Behaviour:
- Reset (async): state IDLE; all buffer bytes 0; neo_data=0; ready_to_load=1; ready_to_send=1; all counters 0.
- Reset mid-packet: neo_data drops to 0 immediately and the buffer is cleared.
- Word format: pixel word is {G,R,B}, 24 bits. Transmission order is pixel 0 first, MSB first.
- Packet length: 24*NUM_PIXELS bits; total SEND time is exactly 24*NUM_PIXELS*BIT_CYC cycles.
- Load rule: write occurs when load_color && ready_to_load.
  - Ignored when pixel_index >= NUM_PIXELS or color_index==11 (without the option).
  - Buffer contents persist across sends; there is no implicit clear.
- IDLE: ready_to_load=1, ready_to_send=1, neo_data=0.
  - send_it -> SEND on the next edge.
  - If load_color and send_it occur together, the load is written and the new value is included in the packet.
- SEND: ready_to_load=0, ready_to_send=0.
  - Per bit: neo_data high for T1H_CYC (bit=1) or T0H_CYC (bit=0) cycles, then low until BIT_CYC elapses.
  - First bit goes high in the first SEND cycle, i.e. 1 cycle after send_it is sampled.
  - load_color and send_it are ignored.
  - After the last bit's final cycle -> LATCH.
- LATCH: neo_data=0, ready_to_load=1, ready_to_send=0.
  - Loads are accepted and affect only the next packet.
  - send_it is ignored, not queued.
  - After LATCH_CYC cycles -> IDLE.
- Counters:
  - bit-phase counter: $clog2(BIT_CYC) bits, wraps at BIT_CYC-1.
  - bit index: 0..23.
  - pixel index: 0..NUM_PIXELS-1.
  - latch counter: $clog2(LATCH_CYC+1) bits.
  - No counter may overflow for the legal parameter range.

Optional Feature:
- Macro: NEOPIXEL_RGBW_EN.
- Defined:
  - Each word is {G,R,B,W}, 32 bits, with W sent last.
  - color_index 11 writes W.
  - Packet length is 32*NUM_PIXELS bits.
- Undefined:
  - 24-bit words.
  - color_index 11 loads are dropped.

Decomposition:
- Package neopixel_pkg:
  - state enum {IDLE, SEND, LATCH}.
  - color index constants CI_RED=2'b00, CI_BLUE=2'b01, CI_GREEN=2'b10, CI_WHITE=2'b11.
  - WORD_BITS constant (24, or 32 under the macro).
  - default timing constants for 50 MHz.
- Sub-module neopixel_bit_encoder:
  - Inputs: bit value, start strobe.
  - Drives the high/low waveform for one bit and pulses done on its last cycle.
  - Parametrised by T0H_CYC, T1H_CYC, BIT_CYC.
- The top level handles the buffer, sequencing and FSM.

Test Plan:
1. Reset, load pixel 0 R=8'hFF, G=8'h00, B=8'h81, send_it -> the first 24 bits are 0x00, 0xFF, 0x81, MSB first. Each 1 bit is high 35 cycles and each 0 bit is high 18 cycles, each bit 63 cycles total. Pixels 1-4 send all zeros.
2. send_it sampled at edge N -> neo_data high at N+1. ready_to_send low for 5*24*63=7560 SEND cycles plus 2500 LATCH cycles, then 1 again.
3. During SEND assert load_color for pixel 2 G=8'h55 and pulse send_it -> buffer unchanged, no second packet. During LATCH load the same -> the next packet carries 0x55 in pixel 2's G byte.
4. Load with pixel_index=7 (NUM_PIXELS=5) and color_index=11 -> buffer unchanged, packet all zeros.
5. Assert reset 1000 cycles into SEND -> neo_data=0 immediately, ready flags=1, a subsequent send emits all zeros.
6. Build with NEOPIXEL_RGBW_EN and NUM_PIXELS=1, load W=8'hA5, send -> 32 bits ending in 1010_0101, SEND lasts 32*63 cycles.

Source files
------------

// File: rtl/neopixel_pkg.sv
// rtl/neopixel_pkg.sv - shared types and constants for the NeoPixel strand driver.
// NEOPIXEL_RGBW_EN widens each pixel word to {G,R,B,W}.
package neopixel_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        LATCH = 2'd2
    } state_t;

    localparam logic [1:0] CI_RED   = 2'b00;
    localparam logic [1:0] CI_BLUE  = 2'b01;
    localparam logic [1:0] CI_GREEN = 2'b10;
    localparam logic [1:0] CI_WHITE = 2'b11;

`ifdef NEOPIXEL_RGBW_EN
    localparam int WORD_BITS = 32;
`else
    localparam int WORD_BITS = 24;
`endif

    // WS2812 timing at a 50 MHz clock
    localparam int DEF_T0H_CYC   = 18;
    localparam int DEF_T1H_CYC   = 35;
    localparam int DEF_BIT_CYC   = 63;
    localparam int DEF_LATCH_CYC = 2500;

endpackage

// File: rtl/neopixel_strand_driver_bit_encoder.sv
// rtl/neopixel_strand_driver_bit_encoder.sv - one WS2812 bit: high for T0H/T1H cycles, low until BIT_CYC.
module neopixel_bit_encoder #(
    parameter int T0H_CYC = 18,
    parameter int T1H_CYC = 35,
    parameter int BIT_CYC = 63
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic bit_value,
    output logic busy,
    output logic data,
    output logic done
);

    localparam int PH_W = $clog2(BIT_CYC);

    logic            active;
    logic [PH_W-1:0] phase;
    logic [PH_W-1:0] cur_phase;
    logic [PH_W-1:0] high_cyc;
    logic            running;

    // start counts as phase 0 so the line rises in the same cycle it is strobed
    always_comb begin
        running   = start | active;
        cur_phase = start ? '0 : phase;
        high_cyc  = bit_value ? PH_W'(T1H_CYC) : PH_W'(T0H_CYC);
        data      = running && (cur_phase < high_cyc);
        done      = running && (cur_phase == PH_W'(BIT_CYC - 1));
    end

    assign busy = active;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            active <= 1'b0;
            phase  <= '0;
        end else if (running) begin
            if (done) begin
                active <= 1'b0;
                phase  <= '0;
            end else begin
                active <= 1'b1;
                phase  <= cur_phase + 1'b1;
            end
        end
    end

endmodule

// File: rtl/neopixel_strand_driver.sv
// rtl/neopixel_strand_driver.sv - colour buffer, packet sequencing and FSM for a WS2812 strand.
// NEOPIXEL_RGBW_EN adds a W channel (color_index 11) sent last in each 32-bit word.
module neopixel_strand_driver
    import neopixel_pkg::*;
#(
    parameter int NUM_PIXELS = 5,
    parameter int T0H_CYC    = DEF_T0H_CYC,
    parameter int T1H_CYC    = DEF_T1H_CYC,
    parameter int BIT_CYC    = DEF_BIT_CYC,
    parameter int LATCH_CYC  = DEF_LATCH_CYC,
    parameter int PIX_W      = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [7:0]       color_level,
    input  logic [1:0]       color_index,
    input  logic [PIX_W-1:0] pixel_index,
    input  logic             load_color,
    input  logic             send_it,
    output logic             neo_data,
    output logic             ready_to_load,
    output logic             ready_to_send
);

    localparam int BIT_W = $clog2(WORD_BITS);
    localparam int LAT_W = $clog2(LATCH_CYC + 1);

    state_t state, state_next;

    logic [7:0] g_buf [NUM_PIXELS];
    logic [7:0] r_buf [NUM_PIXELS];
    logic [7:0] b_buf [NUM_PIXELS];
`ifdef NEOPIXEL_RGBW_EN
    logic [7:0] w_buf [NUM_PIXELS];
`endif

    logic [BIT_W-1:0]     bit_cnt;
    logic [PIX_W-1:0]     pix_cnt;
    logic [LAT_W-1:0]     latch_cnt;
    logic [WORD_BITS-1:0] cur_word;
    logic                 bit_value;
    logic                 ci_ok, load_en, last_bit, last_pixel;
    logic                 enc_start, enc_busy, enc_data, enc_done;

`ifdef NEOPIXEL_RGBW_EN
    assign ci_ok = 1'b1;
`else
    assign ci_ok = (color_index != CI_WHITE);
`endif

    assign load_en    = load_color && ready_to_load && ci_ok && (32'(pixel_index) < NUM_PIXELS);
    assign last_bit   = (bit_cnt == BIT_W'(WORD_BITS - 1));
    assign last_pixel = (pix_cnt == PIX_W'(NUM_PIXELS - 1));
    assign enc_start  = (state == SEND) && !enc_busy;
    assign bit_value  = cur_word[BIT_W'(WORD_BITS - 1) - bit_cnt];
    assign neo_data   = enc_data;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PIXELS; i++) begin
                g_buf[i] <= '0;
                r_buf[i] <= '0;
                b_buf[i] <= '0;
`ifdef NEOPIXEL_RGBW_EN
                w_buf[i] <= '0;
`endif
            end
        end else if (load_en) begin
            for (int i = 0; i < NUM_PIXELS; i++) begin
                if (pixel_index == PIX_W'(i)) begin
                    case (color_index)
                        CI_RED:   r_buf[i] <= color_level;
                        CI_BLUE:  b_buf[i] <= color_level;
                        CI_GREEN: g_buf[i] <= color_level;
                        default: begin
`ifdef NEOPIXEL_RGBW_EN
                            w_buf[i] <= color_level;
`endif
                        end
                    endcase
                end
            end
        end
    end

    always_comb begin
        cur_word = '0;
        for (int i = 0; i < NUM_PIXELS; i++) begin
            if (pix_cnt == PIX_W'(i)) begin
`ifdef NEOPIXEL_RGBW_EN
                cur_word = {g_buf[i], r_buf[i], b_buf[i], w_buf[i]};
`else
                cur_word = {g_buf[i], r_buf[i], b_buf[i]};
`endif
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        ready_to_load = 1'b1;
        ready_to_send = 1'b0;
        case (state)
            IDLE: begin
                ready_to_send = 1'b1;
                if (send_it) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                ready_to_load = 1'b0;
                if (enc_done && last_bit && last_pixel) begin
                    state_next = LATCH;
                end
            end
            LATCH: begin
                if (latch_cnt == LAT_W'(LATCH_CYC - 1)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // bit/pixel counters only move on a finished bit, so cur_word stays stable within a bit
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bit_cnt   <= '0;
            pix_cnt   <= '0;
            latch_cnt <= '0;
        end else begin
            if (state == SEND && enc_done) begin
                if (last_bit) begin
                    bit_cnt <= '0;
                    pix_cnt <= last_pixel ? '0 : pix_cnt + 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
            if (state == LATCH && state_next == LATCH) begin
                latch_cnt <= latch_cnt + 1'b1;
            end else begin
                latch_cnt <= '0;
            end
        end
    end

    neopixel_bit_encoder #(
        .T0H_CYC (T0H_CYC),
        .T1H_CYC (T1H_CYC),
        .BIT_CYC (BIT_CYC)
    ) u_bit_encoder (
        .clock     (clock),
        .reset     (reset),
        .start     (enc_start),
        .bit_value (bit_value),
        .busy      (enc_busy),
        .data      (enc_data),
        .done      (enc_done)
    );

endmodule

// File: tb/tb_neopixel_strand_driver.sv
// tb/tb_neopixel_strand_driver.sv - directed self-checking bench for neopixel_strand_driver.
module tb_neopixel_strand_driver;
    import neopixel_pkg::*;

    localparam int NP   = 5;
    localparam int T0H  = 18;
    localparam int T1H  = 35;
    localparam int BITC = 63;
    localparam int LATC = 2500;
    localparam int WB   = WORD_BITS;
    localparam int NB   = WB * NP;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] color_level = '0;
    logic [1:0] color_index = '0;
    logic [2:0] pixel_index = '0;
    logic       load_color = 1'b0;
    logic       send_it = 1'b0;
    logic       neo_data, ready_to_load, ready_to_send;

    int checks   = 0;
    int failures = 0;

    logic [7:0]   mg [NP];
    logic [7:0]   mr [NP];
    logic [7:0]   mb [NP];
    logic [7:0]   mw [NP];
    logic [159:0] pkt;

    always #5 clock = ~clock;

    neopixel_strand_driver dut (
        .clock         (clock),
        .reset         (reset),
        .color_level   (color_level),
        .color_index   (color_index),
        .pixel_index   (pixel_index),
        .load_color    (load_color),
        .send_it       (send_it),
        .neo_data      (neo_data),
        .ready_to_load (ready_to_load),
        .ready_to_send (ready_to_send)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int p = 0; p < NP; p++) begin
            mg[p] = '0;
            mr[p] = '0;
            mb[p] = '0;
            mw[p] = '0;
        end
    endtask

    function automatic logic [159:0] build_exp();
        logic [159:0] e;
        e = '0;
        for (int p = 0; p < NP; p++) begin
`ifdef NEOPIXEL_RGBW_EN
            e = (e << 32) | 160'({mg[p], mr[p], mb[p], mw[p]});
`else
            e = (e << 24) | 160'({mg[p], mr[p], mb[p]});
`endif
        end
        return e;
    endfunction

    task automatic load(input int pix, input logic [1:0] ci, input logic [7:0] lvl);
        load_color  = 1'b1;
        pixel_index = pix[2:0];
        color_index = ci;
        color_level = lvl;
        tick();
        load_color  = 1'b0;
    endtask

    task automatic inject_load_send();
        load_color  = 1'b1;
        pixel_index = 3'd2;
        color_index = CI_GREEN;
        color_level = 8'h55;
        send_it     = 1'b1;
    endtask

    // Sends one packet, decodes it from pulse widths, then walks the latch gap and a quiet idle window.
    task automatic run_packet(input bit inject, output logic [159:0] got);
        int hi, bad_w, rts_hi, rtl_hi, neo_hi;
        logic bv;
        got = '0;
        bad_w = 0;
        rts_hi = 0;
        rtl_hi = 0;
        send_it = 1'b1;
        tick();
        send_it = 1'b0;
        load_color = 1'b0;
        check("first_bit_high", 160'(neo_data), 160'(1));
        for (int b = 0; b < NB; b++) begin
            hi = 0;
            for (int c = 0; c < BITC; c++) begin
                if (neo_data) hi++;
                if (ready_to_send) rts_hi++;
                if (ready_to_load) rtl_hi++;
                if (inject && b == 3 && c == 10) begin
                    inject_load_send();
                end else begin
                    load_color = 1'b0;
                    send_it = 1'b0;
                end
                tick();
            end
            if (hi == T1H) begin
                bv = 1'b1;
            end else begin
                bv = 1'b0;
                if (hi != T0H) bad_w++;
            end
            got = {got[158:0], bv};
        end
        load_color = 1'b0;
        send_it = 1'b0;
        check("send_pulse_widths_bad", 160'(bad_w), 160'(0));
        check("send_rts_high_cycles", 160'(rts_hi), 160'(0));
        check("send_rtl_high_cycles", 160'(rtl_hi), 160'(0));
        check("latch_entry_rtl", 160'(ready_to_load), 160'(1));
        neo_hi = 0;
        rts_hi = 0;
        for (int c = 0; c < LATC; c++) begin
            if (neo_data) neo_hi++;
            if (ready_to_send) rts_hi++;
            if (inject && c == 500) begin
                inject_load_send();
            end else begin
                load_color = 1'b0;
                send_it = 1'b0;
            end
            tick();
        end
        load_color = 1'b0;
        send_it = 1'b0;
        check("latch_neo_high_cycles", 160'(neo_hi), 160'(0));
        check("latch_rts_high_cycles", 160'(rts_hi), 160'(0));
        check("idle_rts_after_latch", 160'(ready_to_send), 160'(1));
        neo_hi = 0;
        for (int c = 0; c < 100; c++) begin
            if (neo_data) neo_hi++;
            tick();
        end
        check("idle_no_queued_packet", 160'(neo_hi), 160'(0));
    endtask

    initial begin
        clear_model();
        repeat (3) @(posedge clock);
        #1;
        check("reset_neo_data", 160'(neo_data), 160'(0));
        check("reset_ready_to_load", 160'(ready_to_load), 160'(1));
        check("reset_ready_to_send", 160'(ready_to_send), 160'(1));
        reset = 1'b0;
        tick();

        // pixel 0: R=FF, G=00, B=81 (B load coincides with send_it)
        load(0, CI_RED, 8'hFF);
        load(0, CI_GREEN, 8'h00);
        mr[0] = 8'hFF;
        mb[0] = 8'h81;
        load_color  = 1'b1;
        pixel_index = 3'd0;
        color_index = CI_BLUE;
        color_level = 8'h81;
        run_packet(1'b1, pkt);
        check("packet1_contents", pkt, build_exp());

        // only the LATCH-time load of pixel 2 G=55 takes effect
        mg[2] = 8'h55;
        run_packet(1'b0, pkt);
        check("packet2_contents", pkt, build_exp());

        // reset 1008 cycles into SEND, at the rising phase of bit 16
        send_it = 1'b1;
        tick();
        send_it = 1'b0;
        repeat (1008) tick();
        check("pre_reset_neo_high", 160'(neo_data), 160'(1));
        #2 reset = 1'b1;
        #1;
        check("midsend_reset_neo_data", 160'(neo_data), 160'(0));
        check("midsend_reset_rtl", 160'(ready_to_load), 160'(1));
        check("midsend_reset_rts", 160'(ready_to_send), 160'(1));
        clear_model();
        @(posedge clock);
        #1;
        reset = 1'b0;
        tick();

        // out-of-range pixel and reserved channel loads
        load(7, CI_RED, 8'hAA);
        load(1, CI_WHITE, 8'hAA);
`ifdef NEOPIXEL_RGBW_EN
        mw[1] = 8'hAA;
`endif
        run_packet(1'b0, pkt);
        check("packet3_contents", pkt, build_exp());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
